alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequences one ALU operation at a time for the 3-bit ALU datapath (sh_r, sh_l, zero, divisor).
//  - Accepts a valid/ready request: opcode plus operands A and B.
//  - Latches the operands and fires a one-cycle init pulse to the selected unit.
//  - Waits for that unit's done, then returns a 16-bit zero-extended result on a
//    valid/ready response channel feeding the display.
//  - Aborts with an error response if the unit does not finish within TIMEOUT cycles.
// PARAMETERS
//  W        3   operand width, A and B
//  TIMEOUT  64  cycles spent in WAIT before abort; legal range 2..65535
// PORTS
//  clk          in   1   system clock, all logic on the rising edge
//  rst          in   1   synchronous reset, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept a request
//  req_opcode   in   2   00 sh_r, 01 sh_l, 10 isZero, 11 div
//  req_a        in   W   operand A (dividend)
//  req_b        in   W   operand B (divisor)
//  op_a         out  W   latched A to the datapath, stable from ISSUE until the next accept
//  op_b         out  W   latched B to the datapath, stable from ISSUE until the next accept
//  init         out  4   one-hot unit start: bit0 sh_r, bit1 sh_l, bit2 zero, bit3 div
//  unit_done    in   4   per-unit completion, same bit order as init
//  res_sh_r     in   4   sh_r result
//  res_sh_l     in   4   sh_l result
//  res_zero     in   1   zero result
//  res_div      in   W   divisor quotient
//  rsp_valid    out  1   response present
//  rsp_ready    in   1   consumer accepts the response
//  rsp_data     out  16  result, zero-extended
//  rsp_err      out  1   1 = timeout abort; rsp_data is then 0
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  - Reset: while rst=1, state=IDLE and every output is 0, req_ready included; op_a/op_b/timer cleared.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE:
//    - req_ready=1.
//    - On req_valid&req_ready: latch opcode into op_sel, A into op_a, B into op_b; go to ISSUE.
//  - ISSUE (exactly 1 cycle):
//    - init = 4'b0001 << op_sel; all other init bits 0.
//    - timer cleared; go to WAIT.
//  - WAIT:
//    - init=0; timer increments every cycle.
//    - If unit_done[op_sel]=1: capture rsp_data and set rsp_err=0; go to RESP.
//    - Result mux: sh_r {12'b0,res_sh_r}, sh_l {12'b0,res_sh_l}, zero {15'b0,res_zero},
//      div {(16-W)'b0,res_div}.
//    - Else if timer==TIMEOUT-1: rsp_data=0, rsp_err=1; go to RESP.
//    - If done and timeout coincide, done wins (rsp_err=0).
//    - unit_done bits other than op_sel are ignored in every state.
//  - RESP:
//    - rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready=1.
//    - On rsp_valid&rsp_ready: next cycle IDLE, rsp_valid=0. rsp_data and rsp_err keep their last value.
//  - Latency, with accept at cycle 0:
//    - init high at cycle 1; unit_done is sampled from cycle 2.
//    - If done is seen at cycle k, rsp_valid rises at cycle k+1.
//    - Minimum accept-to-response latency is 3 cycles.
//  - Throughput:
//    - One operation in flight; req_ready=0 in ISSUE, WAIT and RESP.
//    - A new request is accepted no earlier than 1 cycle after the response handshake.
//  - Reset mid-operation:
//    - Immediate abort to IDLE; the pending init is not issued or is dropped.
//    - No response is produced.
//  - Timer width is clog2(TIMEOUT); the timer never wraps.
// TESTING
//  - Reset: hold rst 3 cycles, any inputs -> all outputs 0, busy=0; after release, req_ready=1 in IDLE.
//  - sh_r happy path: opcode=00, A=3'b110, unit_done[0] 2 cycles after init, res_sh_r=4'b0011
//    -> init=0001 for exactly 1 cycle; rsp_data=16'h0003, rsp_err=0.
//  - Divide with stalled consumer: opcode=11, A=7, B=2, res_div=3, rsp_ready low 5 cycles
//    -> rsp_valid held with rsp_data=16'h0003; req_valid during the stall is not accepted.
//  - Timeout, TIMEOUT=8: opcode=10, unit_done never asserted
//    -> rsp_valid exactly 8 cycles after the WAIT entry edge, rsp_data=0, rsp_err=1.
//  - Wrong done and coincidence: opcode=01 with unit_done=1000 -> ignored;
//    then unit_done[1] on the timeout cycle -> rsp_err=0, rsp_data={12'b0,res_sh_l}.
//  - Reset mid-WAIT: assert rst during WAIT -> IDLE next cycle, no rsp_valid;
//    the next request completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Runs one operation at a time on the 3-bit ALU datapath (sh_r, sh_l, zero,
// divisor). A request is accepted, its operands are latched and a one-cycle
// init pulse goes to the selected unit. The sequencer then waits for that
// unit's done (or a timeout) and returns a zero-extended 16-bit result on a
// valid/ready response channel. All outputs come straight from flops.
module alu_op_sequencer #(
    parameter int W       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [1:0]    i_req_opcode,
    input  logic [W-1:0]  i_req_a,
    input  logic [W-1:0]  i_req_b,
    output logic [W-1:0]  o_op_a,
    output logic [W-1:0]  o_op_b,
    output logic [3:0]    o_init,
    input  logic [3:0]    i_unit_done,
    input  logic [3:0]    i_res_sh_r,
    input  logic [3:0]    i_res_sh_l,
    input  logic          i_res_zero,
    input  logic [W-1:0]  i_res_div,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [15:0]   o_rsp_data,
    output logic          o_rsp_err,
    output logic          o_busy
);

    // Timer only has to count up to TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Opcode encoding, also the bit index into init / unit_done.
    localparam logic [1:0] OP_SH_R = 2'd0;
    localparam logic [1:0] OP_SH_L = 2'd1;
    localparam logic [1:0] OP_ZERO = 2'd2;
    localparam logic [1:0] OP_DIV  = 2'd3;

    // Registered state and datapath.
    state_t        r_state;
    logic [1:0]    r_op_sel;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_init;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic [15:0]   r_rsp_data;
    logic          r_rsp_err;
    logic          r_busy;

    // Next-state decode outputs.
    state_t        w_next_state;
    logic          w_accept;
    logic          w_done_hit;
    logic          w_timeout_hit;
    logic          w_sel_done;
    logic [15:0]   w_result;

    // Zero-extends the selected unit's result to 16 bits.
    function automatic logic [15:0] f_result(
        input logic [1:0]   sel,
        input logic [3:0]   sh_r,
        input logic [3:0]   sh_l,
        input logic         zero,
        input logic [W-1:0] quo
    );
        logic [15:0] res;
        case (sel)
            OP_SH_R: res = {12'h000, sh_r};
            OP_SH_L: res = {12'h000, sh_l};
            OP_ZERO: res = {15'h0000, zero};
            OP_DIV:  res = {{(16 - W){1'b0}}, quo};
            default: res = 16'h0000;
        endcase
        return res;
    endfunction

    // Only the done bit of the unit that was started counts; the rest are ignored.
    assign w_sel_done = i_unit_done[r_op_sel];
    assign w_result   = f_result(r_op_sel, i_res_sh_r, i_res_sh_l, i_res_zero, i_res_div);

    // Next-state logic; done has priority over a timeout landing on the same cycle.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_done_hit    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ISSUE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_sel_done) begin
                    w_done_hit   = 1'b1;
                    w_next_state = S_RESP;
                end else if (r_timer == TIMER_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = S_RESP;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && i_rsp_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation straight back to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake/status flags are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_req_ready <= (w_next_state == S_IDLE);
            r_rsp_valid <= (w_next_state == S_RESP);
            r_busy      <= (w_next_state != S_IDLE);
        end
    end

    // Operand/opcode capture on accept; held until the next accepted request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_sel <= 2'd0;
            r_op_a   <= '0;
            r_op_b   <= '0;
        end else if (w_accept) begin
            r_op_sel <= i_req_opcode;
            r_op_a   <= i_req_a;
            r_op_b   <= i_req_b;
        end
    end

    // One-hot init is set on the accept edge, so it is high for the single ISSUE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_init <= 4'b0000;
        end else if (w_accept) begin
            r_init <= 4'b0001 << i_req_opcode;
        end else begin
            r_init <= 4'b0000;
        end
    end

    // Wait timer: cleared in ISSUE, counts in WAIT, saturates rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (r_state == S_ISSUE) begin
            r_timer <= '0;
        end else if ((r_state == S_WAIT) && (r_timer != TIMER_LAST)) begin
            r_timer <= r_timer + TIMER_ONE;
        end
    end

    // Response payload is captured when leaving WAIT and held afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_data <= 16'h0000;
            r_rsp_err  <= 1'b0;
        end else if (w_done_hit) begin
            r_rsp_data <= w_result;
            r_rsp_err  <= 1'b0;
        end else if (w_timeout_hit) begin
            r_rsp_data <= 16'h0000;
            r_rsp_err  <= 1'b1;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_op_a      = r_op_a;
    assign o_op_b      = r_op_b;
    assign o_init      = r_init;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: expected responses are queued when a request
// is driven and compared when the response handshake happens.
module tb_alu_op_sequencer;

    localparam int W       = 3;
    localparam int TIMEOUT = 8;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_opcode;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [3:0]    init;
    logic [3:0]    unit_done;
    logic [3:0]    res_sh_r;
    logic [3:0]    res_sh_l;
    logic          res_zero;
    logic [W-1:0]  res_div;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [15:0]   rsp_data;
    logic          rsp_err;
    logic          busy;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    alu_op_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_opcode (req_opcode),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_op_a       (op_a),
        .o_op_b       (op_b),
        .o_init       (init),
        .i_unit_done  (unit_done),
        .i_res_sh_r   (res_sh_r),
        .i_res_sh_l   (res_sh_l),
        .i_res_zero   (res_zero),
        .i_res_div    (res_div),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare each completed response with the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rsp_data", 32'(rsp_data), 32'(e.data));
                check_eq("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    // Drive one request, queue its expected response; returns in the ISSUE cycle.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [15:0] exp_data, input logic exp_err);
        int n;
        exp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        sb_q.push_back(e);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("req_ready_wait", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_eq("init_issue", 32'(init), 32'(4'b0001 << op));
        check_eq("busy_issue", 32'(busy), 32'd1);
        check_eq("ready_issue", 32'(req_ready), 32'd0);
        check_eq("op_a", 32'(op_a), 32'(a));
        check_eq("op_b", 32'(op_b), 32'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_opcode = 2'd3;
        req_a      = 3'd5;
        req_b      = 3'd2;
        unit_done  = 4'hF;
        res_sh_r   = 4'b0011;
        res_sh_l   = 4'b1010;
        res_zero   = 1'b1;
        res_div    = 3'd3;
        rsp_ready  = 1'b1;

        // Reset held 3 cycles with busy inputs: everything must stay 0.
        repeat (3) tick();
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_init", 32'(init), 32'd0);
        check_eq("rst_ops", 32'({op_a, op_b}), 32'd0);
        check_eq("rst_rsp", 32'({rsp_data, rsp_err}), 32'd0);
        rst       = 1'b0;
        req_valid = 1'b0;
        unit_done = 4'h0;
        tick();
        check_eq("idle_ready", 32'(req_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // sh_r happy path: done 2 cycles after init.
        send(2'd0, 3'b110, 3'b001, 16'h0003, 1'b0);
        tick();
        check_eq("init_one_cycle", 32'(init), 32'd0);
        tick();
        unit_done = 4'b0001;
        check_eq("shr_not_yet", 32'(rsp_valid), 32'd0);
        tick();
        unit_done = 4'b0000;
        check_eq("shr_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
        check_eq("shr_rsp_drop", 32'(rsp_valid), 32'd0);
        check_eq("shr_idle_ready", 32'(req_ready), 32'd1);

        // Divide with a stalled consumer; requests during the stall are refused.
        rsp_ready = 1'b0;
        send(2'd3, 3'd7, 3'd2, 16'h0003, 1'b0);
        tick();
        unit_done = 4'b1000;
        tick();
        unit_done = 4'b0000;
        check_eq("div_min_latency", 32'(rsp_valid), 32'd1);
        res_div    = 3'd5;
        req_valid  = 1'b1;
        req_opcode = 2'd0;
        for (int i = 0; i < 5; i++) begin
            check_eq("div_stall_valid", 32'(rsp_valid), 32'd1);
            check_eq("div_stall_data", 32'(rsp_data), 32'h0003);
            check_eq("div_stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check_eq("div_done_valid", 32'(rsp_valid), 32'd0);
        check_eq("div_no_accept", 32'({busy, init}), 32'd0);

        // Timeout on isZero: response exactly TIMEOUT cycles after WAIT entry.
        send(2'd2, 3'd1, 3'd0, 16'h0000, 1'b1);
        tick();
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check_eq("timeout_latency", 32'(n), 32'(TIMEOUT));
        check_eq("timeout_err_out", 32'(rsp_err), 32'd1);
        tick();

        // sh_l: foreign done bit ignored, then own done on the timeout cycle wins.
        res_sh_l = 4'b1010;
        send(2'd1, 3'd2, 3'd4, 16'h000A, 1'b0);
        tick();
        unit_done = 4'b1000;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            check_eq("shl_wrong_done", 32'(rsp_valid), 32'd0);
            tick();
        end
        unit_done = 4'b1010;
        tick();
        unit_done = 4'b0000;
        check_eq("shl_coincide_valid", 32'(rsp_valid), 32'd1);
        tick();

        // Reset during WAIT: abort, no response, then a normal operation.
        send(2'd0, 3'd3, 3'd3, 16'h0003, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_valid", 32'(rsp_valid), 32'd0);
        unit_done = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        unit_done = 4'b0000;
        check_eq("midrst_ready", 32'(req_ready), 32'd1);
        res_sh_r = 4'b0101;
        send(2'd0, 3'd5, 3'd1, 16'h0005, 1'b0);
        unit_done = 4'b0001;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        unit_done = 4'b0000;
        check_eq("post_rst_latency", 32'(n), 32'd2);
        tick();
        tick();

        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
